// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings, funct constants and execute-stage FSM states for the pipelined core.
package pipe_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_R   = 2'b10;
    localparam logic [1:0] OP_I   = 2'b11;
    localparam logic [9:0] F_ADD  = 10'b0000000_000;
    localparam logic [9:0] F_SUB  = 10'b0100000_000;
    localparam logic [9:0] F_AND  = 10'b0000000_111;
    localparam logic [9:0] F_OR   = 10'b0000000_110;
    localparam logic [9:0] F_MUL  = 10'b0000001_000;
    typedef enum logic [1:0] {IDLE, MUL, DONE} ex_state_t;
endpackage

// File: rtl/mul_iter.sv
// mul_iter: shift-add multiplier consuming one multiplier bit per cycle; keeps the low XLEN bits.
module mul_iter #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] acc
);
    localparam int CW = $clog2(MUL_CYCLES) + 1;
    logic [XLEN-1:0] a, b;
    logic [CW-1:0]   count;
    // done marks the cycle performing the final iteration
    assign done = busy && count == CW'(MUL_CYCLES - 1);
    always_ff @(posedge clk_i) begin
        if (rst_i || abort) begin
            busy  <= 1'b0;
            count <= '0;
            acc   <= '0;
            a     <= '0;
            b     <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
            acc   <= '0;
            a     <= a_in;
            b     <= b_in;
        end else if (busy) begin
            if (b[0]) acc <= acc + a;
            a     <= a << 1;
            b     <= b >> 1;
            count <= count + 1'b1;
            busy  <= !done;
        end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage with operand forwarding, ALU, iterative multiply and the EX/MEM register.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0]      ALUOp_i,
    input  logic            RegWrite_i,
    input  logic            MemWrite_i,
    input  logic            MemRead_i,
    input  logic            Mem2Reg_i,
    input  logic            Branch_i,
    input  logic [XLEN-1:0] RSdata_i,
    input  logic [XLEN-1:0] RTdata_i,
    input  logic [XLEN-1:0] STdata_i,
    input  logic [9:0]      funct_i,
    input  logic [4:0]      RDaddr_i,
    input  logic [4:0]      RSaddr_i,
    input  logic [4:0]      RTaddr_i,
    input  logic [XLEN-1:0] WBdata_i,
    input  logic [4:0]      WBaddr_i,
    input  logic            WBRegWrite_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [XLEN-1:0] ALUres_o,
    output logic [XLEN-1:0] STdata_o,
    output logic            Zero_o,
    output logic [4:0]      RDaddr_o,
    output logic            RegWrite_o,
    output logic            MemWrite_o,
    output logic            MemRead_o,
    output logic            Mem2Reg_o,
    output logic            Branch_o
);
    ex_state_t       state_q, state_d;
    logic            ex_ok, wb_ok, rt_elig, is_mul, mul_start, mul_busy, mul_done, bubble;
    logic [XLEN-1:0] op_a, op_b, st_fwd, alu_res, mul_acc, res;

    // a loaded value in EX/MEM is not ready yet, so it never forwards
    assign ex_ok   = RegWrite_o && !MemRead_o && RDaddr_o != '0;
    assign wb_ok   = WBRegWrite_i && WBaddr_i != '0;
    assign rt_elig = ALUOp_i == OP_R || ALUOp_i == OP_SUB;

    assign op_a = ex_ok && RDaddr_o == RSaddr_i ? ALUres_o :
                  wb_ok && WBaddr_i == RSaddr_i ? WBdata_i : RSdata_i;
    assign op_b = rt_elig && ex_ok && RDaddr_o == RTaddr_i ? ALUres_o :
                  rt_elig && wb_ok && WBaddr_i == RTaddr_i ? WBdata_i : RTdata_i;
    assign st_fwd = MemWrite_i && ex_ok && RDaddr_o == RTaddr_i ? ALUres_o :
                    MemWrite_i && wb_ok && WBaddr_i == RTaddr_i ? WBdata_i : STdata_i;

    assign alu_res = ALUOp_i == OP_SUB ? op_a - op_b :
                     ALUOp_i != OP_R   ? op_a + op_b :
                     funct_i == F_ADD  ? op_a + op_b :
                     funct_i == F_SUB  ? op_a - op_b :
                     funct_i == F_AND  ? op_a & op_b :
                     funct_i == F_OR   ? op_a | op_b : '0;

    assign is_mul    = ALUOp_i == OP_R && funct_i == F_MUL;
    assign mul_start = state_q == IDLE && is_mul && !flush_i;
    assign res       = state_q == DONE ? mul_acc : alu_res;

    mul_iter #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .start (mul_start),
        .abort (flush_i),
        .a_in  (op_a),
        .b_in  (op_b),
        .busy  (mul_busy),
        .done  (mul_done),
        .acc   (mul_acc)
    );

    always_comb begin
        state_d = state_q;
        stall_o = !rst_i && !flush_i && (mul_busy || (state_q == IDLE && is_mul));
        bubble  = flush_i || state_q == MUL || (state_q == IDLE && is_mul);
        if (flush_i) state_d = IDLE;
        else state_d = state_q == IDLE ? (is_mul ? MUL : IDLE) :
                       state_q == MUL  ? (mul_done ? DONE : MUL) : IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bubble) begin
            ALUres_o   <= '0;
            STdata_o   <= '0;
            Zero_o     <= 1'b0;
            RDaddr_o   <= '0;
            RegWrite_o <= 1'b0;
            MemWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            Mem2Reg_o  <= 1'b0;
            Branch_o   <= 1'b0;
        end else begin
            ALUres_o   <= res;
            STdata_o   <= st_fwd;
            Zero_o     <= res == '0;
            RDaddr_o   <= RDaddr_i;
            RegWrite_o <= RegWrite_i;
            MemWrite_o <= MemWrite_i;
            MemRead_o  <= MemRead_i;
            Mem2Reg_o  <= Mem2Reg_i;
            Branch_o   <= Branch_i;
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for forwarding, ALU decode, iterative multiply, flush and reset.
module tb_ex_mem_stage;
    import pipe_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, stall_o;
    logic [1:0]  ALUOp_i;
    logic        RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i, Branch_i;
    logic [31:0] RSdata_i, RTdata_i, STdata_i, WBdata_i, ALUres_o, STdata_o;
    logic [9:0]  funct_i;
    logic [4:0]  RDaddr_i, RSaddr_i, RTaddr_i, WBaddr_i, RDaddr_o;
    logic        WBRegWrite_i, Zero_o, RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, Branch_o;

    always #5 clk_i = ~clk_i;

    ex_mem_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .ALUOp_i(ALUOp_i),
        .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
        .Mem2Reg_i(Mem2Reg_i), .Branch_i(Branch_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .STdata_i(STdata_i), .funct_i(funct_i),
        .RDaddr_i(RDaddr_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
        .WBdata_i(WBdata_i), .WBaddr_i(WBaddr_i), .WBRegWrite_i(WBRegWrite_i),
        .flush_i(flush_i), .stall_o(stall_o), .ALUres_o(ALUres_o), .STdata_o(STdata_o),
        .Zero_o(Zero_o), .RDaddr_o(RDaddr_o), .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o),
        .MemRead_o(MemRead_o), .Mem2Reg_o(Mem2Reg_o), .Branch_o(Branch_o)
    );

    localparam logic [4:0] RW = 5'b10000, MW = 5'b01000, BR = 5'b00001;

    typedef struct packed {
        logic [31:0] res, st;
        logic [4:0]  rd, ctl;
        logic        z;
    } ex_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [9:0]  fn;
        logic [4:0]  ctl, rd, rs, rt;
        logic [31:0] rsd, rtd, std;
        logic        wben;
        logic [4:0]  wba;
        logic [31:0] wbd, res, st;
    } stim_t;

    ex_t   sb[$];
    ex_t   e;
    stim_t nop = '0;
    int    errors = 0, checks = 0;

    function automatic ex_t obs();
        return {ALUres_o, STdata_o, RDaddr_o, RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, Branch_o, Zero_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input stim_t s, input bit push);
        ALUOp_i = s.op;
        funct_i = s.fn;
        {RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i, Branch_i} = s.ctl;
        RDaddr_i = s.rd;
        RSaddr_i = s.rs;
        RTaddr_i = s.rt;
        RSdata_i = s.rsd;
        RTdata_i = s.rtd;
        STdata_i = s.std;
        WBRegWrite_i = s.wben;
        WBaddr_i = s.wba;
        WBdata_i = s.wbd;
        if (push) sb.push_back({s.res, s.st, s.rd, s.ctl, s.res == 32'd0});
    endtask

    task automatic test_reset();
        drive('{OP_R, F_ADD, 5'b11111, 5'd7, 5'd1, 5'd2, 32'h11, 32'h22, 32'h33, 1'b1, 5'd1, 32'h5, 32'h0, 32'h0}, 1'b0);
        rst_i = 1'b1;
        step();
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs()); end
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        rst_i = 1'b0;
        drive(nop, 1'b0);
        step();
    endtask

    task automatic test_add_chain();
        stim_t t[2] = '{
            '{OP_R, F_ADD, RW, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 32'd0, 32'd12, 32'd0},
            '{OP_R, F_ADD, RW, 5'd4, 5'd3, 5'd1, 32'd0, 32'd5, 32'd0, 1'b0, 5'd0, 32'd0, 32'd17, 32'd0}};
        foreach (t[i]) begin
            drive(t[i], 1'b1);
            step();
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL add_chain[%0d]: got %h want %h", i, obs(), e); end
        end
    endtask

    task automatic test_alu_ops();
        stim_t t[5] = '{
            '{OP_R, F_SUB, RW, 5'd20, 5'd21, 5'd22, 32'd10, 32'd3, 32'd0, 1'b0, 5'd0, 32'd0, 32'd7, 32'd0},
            '{OP_R, F_AND, RW, 5'd20, 5'd21, 5'd22, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 5'd0, 32'd0, 32'hF000, 32'd0},
            '{OP_R, F_OR, RW, 5'd20, 5'd21, 5'd22, 32'hF0, 32'h0F, 32'd0, 1'b0, 5'd0, 32'd0, 32'hFF, 32'd0},
            '{OP_R, 10'h3FF, RW, 5'd20, 5'd21, 5'd22, 32'd1, 32'd2, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0},
            '{OP_R, F_ADD, RW, 5'd20, 5'd21, 5'd22, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1, 32'd0}};
        foreach (t[i]) begin
            drive(t[i], 1'b1);
            step();
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL alu_ops[%0d]: got %h want %h", i, obs(), e); end
        end
    endtask

    task automatic test_fwd_priority();
        stim_t t[5] = '{
            '{OP_I, 10'd0, RW, 5'd5, 5'd0, 5'd0, 32'd0, 32'd9, 32'd0, 1'b0, 5'd0, 32'd0, 32'd9, 32'd0},
            '{OP_R, F_ADD, RW, 5'd6, 5'd5, 5'd0, 32'd100, 32'd0, 32'd0, 1'b1, 5'd5, 32'd1, 32'd9, 32'd0},
            '{OP_R, F_ADD, RW, 5'd7, 5'd5, 5'd2, 32'd100, 32'd3, 32'd0, 1'b1, 5'd5, 32'd1, 32'd4, 32'd0},
            '{OP_I, 10'd0, RW, 5'd0, 5'd0, 5'd0, 32'd0, 32'd50, 32'd0, 1'b1, 5'd5, 32'd1, 32'd50, 32'd0},
            '{OP_R, F_ADD, RW, 5'd8, 5'd0, 5'd0, 32'd11, 32'd22, 32'd0, 1'b1, 5'd0, 32'd99, 32'd33, 32'd0}};
        foreach (t[i]) begin
            drive(t[i], 1'b1);
            step();
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL fwd_priority[%0d]: got %h want %h", i, obs(), e); end
        end
    endtask

    task automatic test_beq_addi_store();
        stim_t t[5] = '{
            '{OP_I, 10'd0, RW, 5'd9, 5'd0, 5'd0, 32'd0, 32'h40, 32'd0, 1'b0, 5'd0, 32'd0, 32'h40, 32'd0},
            '{OP_SUB, 10'd0, BR, 5'd0, 5'd9, 5'd9, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0},
            '{OP_I, 10'd0, RW, 5'd11, 5'd0, 5'd0, 32'd0, 32'h55, 32'd0, 1'b0, 5'd0, 32'd0, 32'h55, 32'd0},
            '{OP_I, 10'd0, RW, 5'd12, 5'd0, 5'd11, 32'd0, 32'd7, 32'd0, 1'b0, 5'd0, 32'd0, 32'd7, 32'd0},
            '{OP_ADD, 10'd0, MW, 5'd0, 5'd0, 5'd12, 32'h100, 32'd8, 32'd0, 1'b0, 5'd0, 32'd0, 32'h108, 32'd7}};
        foreach (t[i]) begin
            drive(t[i], 1'b1);
            step();
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin errors++; $display("FAIL beq_addi_store[%0d]: got %h want %h", i, obs(), e); end
        end
    endtask

    task automatic test_mul();
        int n = 0, bad = 0;
        drive('{OP_R, F_MUL, RW, 5'd13, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFD, 32'd0}, 1'b1);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL mul_stall_start: got %b want 1", stall_o); end
        while (stall_o === 1'b1 && n < 40) begin
            step();
            n++;
            if (n == 1) begin WBRegWrite_i = 1'b1; WBaddr_i = 5'd1; WBdata_i = 32'd5; end
            if (obs() !== '0) bad++;
        end
        checks++;
        if (n != 33) begin errors++; $display("FAIL mul_stall_cycles: got %0d want 33", n); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mul_bubbles: got %0d non-bubble cycles want 0", bad); end
        step();
        drive(nop, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL mul_result: got %h want %h", obs(), e); end
    endtask

    task automatic test_mul_flush();
        stim_t m = '{OP_R, F_MUL, RW, 5'd14, 5'd1, 5'd2, 32'd7, 32'd6, 32'd0, 1'b0, 5'd0, 32'd0, 32'd42, 32'd0};
        int bad = 0;
        drive(m, 1'b0);
        flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b want 0", stall_o); end
        step();
        flush_i = 1'b0;
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL flush_idle_bubble: got %h want 0", obs()); end
        repeat (10) step();
        flush_i = 1'b1;
        drive(nop, 1'b0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_mul_stall: got %b want 0", stall_o); end
        step();
        flush_i = 1'b0;
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL flush_mul_bubble: got %h want 0", obs()); end
        repeat (40) begin
            step();
            if (RegWrite_o !== 1'b0 || ALUres_o === 32'd42 || stall_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL flush_no_writeback: got %0d bad cycles want 0", bad); end
        m.rd = 5'd15;
        drive(m, 1'b0);
        repeat (6) step();
        rst_i = 1'b1;
        drive(nop, 1'b0);
        step();
        rst_i = 1'b0;
        checks++;
        if (obs() !== '0 || stall_o !== 1'b0) begin errors++; $display("FAIL reset_mid_mul: got %h stall %b want 0", obs(), stall_o); end
        bad = 0;
        repeat (40) begin
            step();
            if (RegWrite_o !== 1'b0 || ALUres_o === 32'd42 || stall_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_no_writeback: got %0d bad cycles want 0", bad); end
        drive('{OP_R, F_ADD, RW, 5'd16, 5'd21, 5'd22, 32'd2, 32'd3, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd0}, 1'b1);
        step();
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL after_flush_add: got %h want %h", obs(), e); end
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        drive(nop, 1'b0);
        repeat (2) step();
        test_reset();
        test_add_chain();
        test_alu_ops();
        test_fwd_priority();
        test_beq_addi_store();
        test_mul();
        test_mul_flush();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register of the pipelined RISC-V core. It consumes the ID/EX register outputs and forwards operands from EX/MEM and MEM/WB. It computes the ALU result, or an iterative 32-cycle multiply that stalls upstream, and registers everything into EX/MEM for the memory stage.

## Interface
Parameters:
- XLEN, 32, datapath width
- MUL_CYCLES, 32, multiplier iterations (one multiplier bit per cycle)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- ALUOp_i  in  2  from ID/EX: 00 add (ld/sd), 01 sub (beq), 10 R-type, 11 I-type (addi)
- RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i, Branch_i  in  1 each  control bits from ID/EX
- RSdata_i  in  XLEN  rs1 value from ID/EX
- RTdata_i  in  XLEN  rs2 value, or immediate when ALUSrc was set
- STdata_i  in  XLEN  raw rs2 value (store data) from ID/EX
- funct_i  in  10  {funct7, funct3}
- RDaddr_i, RSaddr_i, RTaddr_i  in  5 each  register addresses
- WBdata_i  in  XLEN  MEM/WB writeback value
- WBaddr_i  in  5  MEM/WB destination
- WBRegWrite_i  in  1  MEM/WB write enable
- flush_i  in  1  squash the instruction currently in EX
- stall_o  out  1  hold PC, IF/ID and ID/EX this cycle
- ALUres_o  out  XLEN  EX/MEM result
- STdata_o  out  XLEN  EX/MEM store data
- Zero_o  out  1  registered (result == 0)
- RDaddr_o  out  5  EX/MEM destination
- RegWrite_o, MemWrite_o, MemRead_o, Mem2Reg_o, Branch_o  out  1 each  EX/MEM control

## Operation
- Forwarding, per source operand:
  - EX/MEM match (RegWrite_o, MemRead_o=0, RDaddr_o≠0, address equal) has first priority.
  - MEM/WB match (WBRegWrite_i, WBaddr_i≠0) has second priority.
  - Otherwise the ID/EX value is used.
  - rs1 is always eligible.
  - rs2 operand is eligible only for ALUOp 10 and 01; other ALUOps carry the immediate.
  - STdata is eligible when MemWrite_i=1.
  - x0 is never forwarded.
- Load-use hazards are the hazard unit's job, not this block's.
- ALU decode:
  - 00/11: a+b.
  - 01: a−b.
  - 10 by funct: 0000000_000 add, 0100000_000 sub, 0000000_111 and, 0000000_110 or, 0000001_000 mul.
  - Unknown funct: result 0, controls pass unchanged.
- Arithmetic: all ops mod 2^XLEN. mul keeps the low XLEN bits, so signedness is irrelevant.
- FSM states IDLE, MUL, DONE:
  - IDLE, mul decoded and flush_i=0: stall_o=1; latch forwarded a and b into the multiplier; clear the accumulator and count; go to MUL.
  - MUL: stall_o=1. Each cycle: if b[0], acc+=a; a<<=1; b>>=1; count++. After MUL_CYCLES iterations go to DONE.
  - DONE: stall_o=0; EX/MEM loads acc plus the held controls; go to IDLE.
- EX/MEM load rule:
  - Non-mul in IDLE with flush_i=0: load the result each cycle.
  - IDLE-with-mul and MUL: load a bubble (all control outputs 0, RDaddr_o 0, data 0).
- flush_i=1 in any state: EX/MEM loads a bubble; FSM returns to IDLE; stall_o=0 that cycle.
- Upstream requirement: ID/EX must hold its outputs while stall_o=1.

## Timing
- Reset: all outputs 0, stall_o 0, FSM IDLE, count 0. Reset mid-MUL aborts the multiply with no writeback.
- Non-mul latency: 1 cycle (inputs at cycle T appear on the outputs after the T edge).
- Mul presented at cycle T:
  - stall_o high for cycles T..T+MUL_CYCLES (33 cycles with defaults).
  - DONE at T+33.
  - Result on ALUres_o from T+34.
  - ID/EX advances at the end of T+33.
- stall_o is combinational from state and decode; no other output is combinational.
- Forwarded operands for mul are sampled only at the IDLE edge. Later MEM/WB changes do not affect the product.
- flush_i together with a mul arriving in IDLE: no stall, bubble loaded.

## Structure
- Shared package pipe_pkg holds:
  - ALUOp encodings.
  - funct constants (F_ADD, F_SUB, F_AND, F_OR, F_MUL).
  - The ex_state_t enum {IDLE, MUL, DONE}.
  - The XLEN default.
- One sub-module, mul_iter: shift-add multiplier with start/busy/done and count. Forwarding, ALU, FSM and the EX/MEM register live in ex_mem_stage.

## Test plan
- Reset: assert rst_i with nonzero inputs → all outputs 0 after the edge, stall_o 0.
- add chain:
  - Stimulus: add x3=x1+x2 (5+7), then add x4=x3+x1 with stale RSdata_i=0.
  - Response: EX/MEM forward gives ALUres_o 12, then 17.
- MEM/WB vs EX/MEM priority: both sources target x5, with WBdata_i=1 and EX/MEM value 9 → operand uses 9; with x0 as destination, no forwarding occurs.
- mul 0xFFFF_FFFF × 3:
  - stall_o high exactly 33 cycles; bubbles on EX/MEM meanwhile.
  - ALUres_o=0xFFFF_FFFD at T+34, with RegWrite_o=1.
- flush_i at MUL cycle 10 → IDLE next cycle, stall_o 0, EX/MEM bubble, no product written.
- beq with equal forwarded operands (both 0x40) → ALUres_o 0, Zero_o 1, Branch_o 1. addi with ALUOp 11 and RTaddr_i matching EX/MEM → immediate used, no rs2 forward.
